// File: rtl/riscv_pkg.sv
// riscv_pkg: access-size encodings and load/store unit state type
package riscv_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed lane of a read word and sign/zero-extends it
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[8*offset +: 8];
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        data = size == SIZE_BYTE ? {{24{~load_unsigned & b[7]}}, b} :
               size == SIZE_HALF ? {{16{~load_unsigned & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access unit with req/ready bus and core stall
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [1:0]        bit_half_word_select,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);
    lsu_state_t        state, state_next;
    logic              req, fault, start;
    logic [1:0]        off_q, size_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata, aligned;
    logic [3:0]        wstrb;
    always_comb begin
        req = mem_read_enable | mem_write_enable;
        fault = bit_half_word_select == 2'b11 |
                (bit_half_word_select == SIZE_HALF & addr[0]) |
                (bit_half_word_select == SIZE_WORD & |addr[1:0]);
        start = state == IDLE & req & ~fault;
        misaligned = state == IDLE & req & fault;
        bus_req = state == REQ;
        stall = start | bus_req;
        state_next = state == IDLE ? (start ? REQ : IDLE) :
                     state == REQ  ? (bus_ready ? DONE : REQ) : IDLE;
    end
    always_comb begin
        wdata = bit_half_word_select == SIZE_BYTE ? {4{store_data[7:0]}} :
                bit_half_word_select == SIZE_HALF ? {2{store_data[15:0]}} : store_data;
        wstrb = ~mem_write_enable ? 4'b0000 :
                bit_half_word_select == SIZE_BYTE ? 4'b0001 << addr[1:0] :
                bit_half_word_select == SIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    // Bus fields are captured once at issue so they stay stable through REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_we <= 1'b0;
            bus_addr <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
            off_q <= 2'b00;
            size_q <= 2'b00;
            uns_q <= 1'b0;
            load_data <= '0;
        end else begin
            if (start) begin
                bus_we <= mem_write_enable;
                bus_addr <= {addr[ADDR_W-1:2], 2'b00};
                bus_wdata <= wdata;
                bus_wstrb <= wstrb;
                off_q <= addr[1:0];
                size_q <= bit_half_word_select;
                uns_q <= load_unsigned;
            end
            if (misaligned & ~mem_write_enable) load_data <= '0;
            if (state == REQ & bus_ready & ~bus_we) load_data <= aligned;
        end
    end
    load_align u_align (
        .rdata(bus_rdata),
        .offset(off_q),
        .size(size_q),
        .load_unsigned(uns_q),
        .data(aligned)
    );
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against an arithmetic reference model
module tb_load_store_unit;
    typedef struct {
        logic        fault;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] ld;
    } exp_t;

    logic        clk = 0, rst = 1;
    logic        mem_read_enable = 0, mem_write_enable = 0, load_unsigned = 0;
    logic [1:0]  bit_half_word_select = 0;
    logic [31:0] addr = 0, store_data = 0, load_data, bus_addr, bus_wdata, bus_rdata = 0;
    logic        stall, misaligned, bus_req, bus_we, bus_ready = 0;
    logic [3:0]  bus_wstrb;

    int          checks = 0, failures = 0;
    exp_t        q[$];
    logic [31:0] last_ld = 0, cur_rdata = 0;
    int          cur_wait = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .bit_half_word_select(bit_half_word_select), .load_unsigned(load_unsigned),
        .addr(addr), .store_data(store_data), .load_data(load_data),
        .stall(stall), .misaligned(misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_fault(input logic [1:0] sel, input logic [31:0] a);
        return sel == 2'b11 || (a % (32'd1 << sel)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sel, input logic uns);
        int     bytes = 1 << sel;
        longint v;
        v = (longint'(w) >> (8 * (sel == 2'b10 ? 0 : a % 4))) & ((longint'(1) << (8 * bytes)) - 1);
        if (!uns && bytes < 4 && v >= (longint'(1) << (8 * bytes - 1))) v -= longint'(1) << (8 * bytes);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sel);
        return sel == 2'b00 ? {24'b0, d[7:0]} * 32'h01010101 :
               sel == 2'b01 ? {16'b0, d[15:0]} * 32'h00010001 : d;
    endfunction

    // Bus slave: holds ready low for cur_wait REQ cycles, toggles it randomly when idle.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                if (cnt == cur_wait) begin
                    bus_ready = 1;
                    bus_rdata = cur_rdata;
                end else begin
                    bus_ready = 0;
                    bus_rdata = $urandom;
                    cnt++;
                end
            end else begin
                cnt = 0;
                bus_ready = 1'($urandom % 2);
                bus_rdata = $urandom;
            end
        end
    end

    // Monitor: compares bus activity and faults with the scoreboard queue.
    initial begin
        bit          pend = 0, pend_done = 0;
        logic [31:0] pend_ld = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("load_data", load_data, pend_ld);
                pend = 0;
            end
            if (pend_done) begin
                chk("done_stall", 32'(stall), 0);
                chk("done_req", 32'(bus_req), 0);
                pend_done = 0;
            end
            if (!rst && misaligned) begin
                chk("fault_stall", 32'(stall), 0);
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_fault: got misaligned=1 expected no fault at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("fault_kind", 32'(e.fault), 1);
                    pend = 1; pend_ld = e.ld;
                end
            end
            if (!rst && bus_req) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_req: got bus_req=1 expected idle at %0t", $time);
                end else begin
                    e = q[0];
                    chk("txn_kind", 32'(e.fault), 0);
                    chk("bus_we", 32'(bus_we), 32'(e.we));
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
                    chk("req_stall", 32'(stall), 1);
                    if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
                    if (bus_ready) begin
                        void'(q.pop_front());
                        pend = 1; pend_done = 1; pend_ld = e.ld;
                    end
                end
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sel, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rw,
                         input int w, input int hold);
        exp_t e;
        int   n;
        mem_read_enable = rd; mem_write_enable = wr; bit_half_word_select = sel;
        load_unsigned = uns; addr = a; store_data = d;
        cur_rdata = rw; cur_wait = w;
        if (is_fault(sel, a)) begin
            if (!wr) last_ld = 0;
            e = '{fault: 1, we: wr, addr: 0, wdata: 0, wstrb: 0, ld: last_ld};
            repeat (hold) q.push_back(e);
            repeat (hold) @(posedge clk);
            #1;
        end else begin
            if (!wr) last_ld = model_load(rw, a, sel, uns);
            e = '{fault: 0, we: wr, addr: {a[31:2], 2'b00}, wdata: model_wdata(d, sel),
                  wstrb: wr ? 4'(((1 << (1 << sel)) - 1) << (a % 4)) : 4'b0000, ld: last_ld};
            q.push_back(e);
            n = 0;
            @(negedge clk);
            while (stall && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("stall_cycles", n, w + 2);
            @(posedge clk);
            #1;
        end
        mem_read_enable = 0; mem_write_enable = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_misaligned", 32'(misaligned), 0);
        chk("rst_wstrb", 32'(bus_wstrb), 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_load_data", load_data, 0);
        @(posedge clk); #1;
        issue(0, 1, 2'b10, 0, 32'h104, 32'hDEADBEEF, 0, 1, 1);
        issue(0, 1, 2'b00, 0, 32'h203, 32'h000000A5, 0, 0, 1);
        issue(1, 0, 2'b00, 0, 32'h102, 0, 32'h1280FF34, 2, 1);
        issue(1, 0, 2'b00, 1, 32'h102, 0, 32'h1280FF34, 0, 1);
        issue(1, 0, 2'b01, 0, 32'h102, 0, 32'h1280FF34, 3, 1);
        issue(1, 0, 2'b10, 0, 32'h106, 0, 0, 0, 2);
        issue(0, 1, 2'b01, 0, 32'h101, 32'h1234, 0, 0, 1);
        issue(1, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D, 32'h55555555, 1, 1);
        issue(1, 0, 2'b11, 0, 32'h20, 0, 0, 0, 1);
        // Abandon a read mid-REQ with reset.
        q.push_back('{fault: 0, we: 0, addr: 32'h300, wdata: 0, wstrb: 0, ld: 0});
        mem_read_enable = 1; bit_half_word_select = 2'b10; addr = 32'h300; cur_wait = 20;
        repeat (2) @(posedge clk);
        #1 rst = 1; mem_read_enable = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("abort_req", 32'(bus_req), 0);
        chk("abort_stall", 32'(stall), 0);
        chk("abort_we", 32'(bus_we), 0);
        chk("abort_addr", bus_addr, 0);
        chk("abort_wdata", bus_wdata, 0);
        chk("abort_wstrb", 32'(bus_wstrb), 0);
        chk("abort_load_data", load_data, 0);
        q.delete();
        last_ld = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            logic        rd, wr;
            logic [31:0] a;
            rd = 1'($urandom % 2);
            wr = rd ? 1'($urandom % 2) : 1'b1;
            a = $urandom;
            issue(rd, wr, 2'($urandom % 4), 1'($urandom % 2), a, $urandom, $urandom,
                  $urandom % 4, 1 + $urandom % 2);
            if ($urandom % 3 == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (5) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
